// File: rtl/lut_table_loader.sv
// -----------------------------------------------------------------------------
// lut_table_loader
//
// Purpose:
//   Runtime-loadable truth-table bank for LogicNets-style LUT neurons. Table
//   contents stream in over a valid/ready configuration port, CFG_W bits per
//   beat, LSB first, into a flat bit array. Once a complete load has been
//   accepted, every neuron is looked up in parallel with a one-cycle
//   registered result.
//
//   Flat table bit i = n*2^FANIN*OUT_BITS + a*OUT_BITS + b
//   (neuron n, entry a, bit b); beat k carries bits [k*CFG_W +: CFG_W].
//
// Optional feature:
//   LUT_LOADER_PARITY_EN - when defined, every accepted beat must satisfy
//   ^{cfg_data, cfg_par} == 0 (even parity). A failing beat is not written,
//   sets cfg_err and abandons the load. When undefined, cfg_par is ignored.
//
// Ports:
//   clk        in   single rising-edge clock
//   rst        in   synchronous active-high reset
//   cfg_valid  in   configuration beat valid
//   cfg_ready  out  configuration beat accepted (high in EMPTY and LOAD)
//   cfg_data   in   CFG_W table bits, LSB first
//   cfg_last   in   marks final beat of a load
//   cfg_par    in   even-parity bit over cfg_data (parity build only)
//   cfg_err    out  sticky load-error flag
//   reload     in   single-cycle request to discard tables and reload
//   loaded     out  tables valid, lookups enabled
//   in_valid   in   lookup request
//   in_addr    in   neuron n address at [n*FANIN +: FANIN]
//   out_valid  out  lookup result valid (one cycle after in_valid)
//   out_data   out  neuron n result at [n*OUT_BITS +: OUT_BITS]
// -----------------------------------------------------------------------------
module lut_table_loader #(
    parameter int FANIN       = 6,
    parameter int NUM_NEURONS = 8,
    parameter int OUT_BITS    = 1,
    parameter int CFG_W       = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [CFG_W-1:0]                cfg_data,
    input  logic                            cfg_last,
    input  logic                            cfg_par,
    output logic                            cfg_err,
    input  logic                            reload,
    output logic                            loaded,
    input  logic                            in_valid,
    input  logic [NUM_NEURONS*FANIN-1:0]    in_addr,
    output logic                            out_valid,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data
);

    localparam int DEPTH       = 1 << FANIN;
    localparam int NEURON_BITS = DEPTH * OUT_BITS;
    localparam int TOTAL_BITS  = NUM_NEURONS * NEURON_BITS;
    localparam int BEATS       = TOTAL_BITS / CFG_W;
    localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W       = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_RUN
    } state_t;

    // Control state
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic                     r_loaded;
    logic                     w_loaded_nxt;
    logic                     r_err;
    logic                     w_err_nxt;
    logic                     w_wr_en;

    // Datapath
    logic [TOTAL_BITS-1:0]              r_table;
    logic [IDX_W-1:0]                   w_wr_idx;
    logic [NUM_NEURONS*OUT_BITS-1:0]    w_lookup;
    logic                               r_out_valid;
    logic [NUM_NEURONS*OUT_BITS-1:0]    r_out_data;

    logic w_accept;
    logic w_last_beat;
    logic w_par_ok;

`ifdef LUT_LOADER_PARITY_EN
    // Even parity across data plus parity bit must reduce to zero.
    assign w_par_ok = ~(^{cfg_data, cfg_par});
`else
    logic w_unused_par;
    assign w_unused_par = cfg_par;
    assign w_par_ok     = 1'b1;
`endif

    assign cfg_ready   = (r_state != S_RUN);
    assign loaded      = r_loaded;
    assign cfg_err     = r_err;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;

    assign w_accept    = cfg_valid && cfg_ready;
    assign w_last_beat = (r_cnt == LAST_CNT);
    assign w_wr_idx    = IDX_W'(r_cnt) * IDX_W'(CFG_W);

    // -------------------------------------------------------------------------
    // Load FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_EMPTY;
            r_cnt    <= '0;
            r_loaded <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking (<=) so every flop samples
            // pre-edge values; combinational blocks below use blocking (=).
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_loaded <= w_loaded_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Load FSM: next state. EMPTY and LOAD share the beat-handling path since
    // the counter is already zero in EMPTY.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path can
        // leave a signal unassigned and infer a latch.
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_loaded_nxt = r_loaded;
        w_err_nxt    = r_err;
        w_wr_en      = 1'b0;

        if (reload) begin
            // Any beat offered alongside reload is dropped.
            w_state_nxt  = S_EMPTY;
            w_cnt_nxt    = '0;
            w_loaded_nxt = 1'b0;
        end else begin
            unique case (r_state)
                S_EMPTY, S_LOAD: begin
                    if (w_accept) begin
                        if (!w_par_ok) begin
                            w_state_nxt = S_EMPTY;
                            w_cnt_nxt   = '0;
                            w_err_nxt   = 1'b1;
                        end else begin
                            w_wr_en = 1'b1;
                            if (w_last_beat && cfg_last) begin
                                w_state_nxt  = S_RUN;
                                w_cnt_nxt    = '0;
                                w_loaded_nxt = 1'b1;
                                w_err_nxt    = 1'b0;
                            end else if (w_last_beat || cfg_last) begin
                                // Framing error: last flag early or missing.
                                w_state_nxt = S_EMPTY;
                                w_cnt_nxt   = '0;
                                w_err_nxt   = 1'b1;
                            end else begin
                                w_state_nxt = S_LOAD;
                                w_cnt_nxt   = r_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_RUN: begin
                    // Configuration port is closed; nothing to do until reload.
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Table storage
    // -------------------------------------------------------------------------
    // NOTE: the table has no reset; its contents only matter once a complete
    // load has set loaded, and leaving it unreset lets it map to plain RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_table[w_wr_idx +: CFG_W] <= cfg_data;
        end
    end

    // One read port per neuron, all addressed in parallel.
    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_rd
        logic [IDX_W-1:0] w_rd_idx;
        assign w_rd_idx = IDX_W'(n * NEURON_BITS)
                        + IDX_W'(in_addr[n*FANIN +: FANIN]) * IDX_W'(OUT_BITS);
        assign w_lookup[n*OUT_BITS +: OUT_BITS] = r_table[w_rd_idx +: OUT_BITS];
    end

    // -------------------------------------------------------------------------
    // Registered lookup result. A lookup issued in the same cycle as reload is
    // still served, because r_loaded only drops on the following edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= in_valid && r_loaded;
            if (in_valid && r_loaded) begin
                r_out_data <= w_lookup;
            end
        end
    end

endmodule

// File: tb/tb_lut_table_loader.sv
// -----------------------------------------------------------------------------
// tb_lut_table_loader
//
// Purpose:
//   Directed self-checking bench for lut_table_loader with default parameters
//   (FANIN=6, NUM_NEURONS=8, OUT_BITS=1, CFG_W=8 -> 64 beats per load).
//   Expected values are hand-computed constants. Honors LUT_LOADER_PARITY_EN
//   for the parity scenario.
// -----------------------------------------------------------------------------
module tb_lut_table_loader;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_data;
    logic        cfg_last;
    logic        cfg_par;
    logic        cfg_err;
    logic        reload;
    logic        loaded;
    logic        in_valid;
    logic [47:0] in_addr;
    logic        out_valid;
    logic [7:0]  out_data;

    int n_tests = 0;
    int n_fail  = 0;

    lut_table_loader dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .cfg_par   (cfg_par),
        .cfg_err   (cfg_err),
        .reload    (reload),
        .loaded    (loaded),
        .in_valid  (in_valid),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream n_beats consecutive beats of tbl; cfg_last on beat last_at,
    // parity inverted on beat bad_par_at (-1 disables either).
    task automatic send_cfg(input logic [511:0] tbl, input int n_beats,
                            input int last_at, input int bad_par_at);
        for (int k = 0; k < n_beats; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = tbl[k*8 +: 8];
            cfg_last  = (k == last_at);
            cfg_par   = (^tbl[k*8 +: 8]) ^ (k == bad_par_at);
            tick();
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        cfg_par   = 1'b0;
    endtask

    // Single-cycle lookup; result is visible when the task returns.
    task automatic lookup(input logic [47:0] addr);
        in_addr  = addr;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    logic [511:0] tbl_a5;
    logic [511:0] tbl_oh;
    logic [47:0]  addr_zero;
    logic [47:0]  addr_idx;
    logic [47:0]  addr_one;
    logic [47:0]  addr_n3;
    logic [47:0]  pipe_addr [4];
    logic [7:0]   pipe_exp  [4];
    logic         exp_err;
    logic         exp_ld;

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        cfg_last  = 1'b0;
        cfg_par   = 1'b0;
        reload    = 1'b0;
        in_valid  = 1'b0;
        in_addr   = '0;

        tbl_a5 = {64{8'hA5}};
        tbl_oh = '0;
        tbl_oh[3*64 + 42] = 1'b1;             // neuron 3, entry 6'h2A

        addr_zero = '0;
        addr_idx  = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
        addr_one  = {8{6'd1}};
        addr_n3   = {6'd0, 6'd0, 6'd0, 6'd0, 6'h2A, 6'd0, 6'd0, 6'd0};

        pipe_addr[0] = addr_n3;                                              pipe_exp[0] = 8'h08;
        pipe_addr[1] = {6'd0, 6'd0, 6'd0, 6'd0, 6'h2B, 6'd0, 6'd0, 6'd0};   pipe_exp[1] = 8'h00;
        pipe_addr[2] = {6'd0, 6'd0, 6'h2A, 6'd0, 6'h2A, 6'd0, 6'd0, 6'd0};  pipe_exp[2] = 8'h08;
        pipe_addr[3] = {8{6'h2A}};                                           pipe_exp[3] = 8'h08;

        // ---- Reset state ----
        tick();
        tick();
        rst = 1'b0;
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_loaded",    loaded,    0);
        check("rst_cfg_err",   cfg_err,   0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);

        // ---- Full load of 0xA5, then lookups ----
        send_cfg(tbl_a5, 64, 63, -1);
        check("a5_loaded",    loaded,    1);
        check("a5_cfg_err",   cfg_err,   0);
        check("a5_cfg_ready", cfg_ready, 0);
        lookup(addr_zero);                    // issued the cycle loaded rises
        check("a5_addr0_valid", out_valid, 1);
        check("a5_addr0_data",  out_data,  8'hFF);
        lookup(addr_idx);                     // neuron n reads entry n
        check("a5_idx_data", out_data, 8'hA5);
        lookup(addr_one);
        check("a5_addr1_data", out_data, 8'h00);

        // ---- reload together with a lookup in RUN ----
        in_addr  = addr_zero;
        in_valid = 1'b1;
        reload   = 1'b1;
        tick();
        in_valid = 1'b0;
        reload   = 1'b0;
        check("reload_out_valid", out_valid, 1);
        check("reload_out_data",  out_data,  8'hFF);
        check("reload_loaded",    loaded,    0);
        check("reload_cfg_ready", cfg_ready, 1);
        lookup(addr_zero);
        check("empty_drop_valid", out_valid, 0);
        check("empty_hold_data",  out_data,  8'hFF);

        // ---- One-hot table, back-to-back lookups ----
        send_cfg(tbl_oh, 64, 63, -1);
        check("oh_loaded", loaded, 1);
        in_valid = 1'b1;
        in_addr  = pipe_addr[0];
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("pipe%0d_valid", i - 1), out_valid, 1);
            check($sformatf("pipe%0d_data", i - 1),  out_data,  pipe_exp[i-1]);
            in_addr = pipe_addr[i];
        end
        tick();
        in_valid = 1'b0;
        check("pipe3_valid", out_valid, 1);
        check("pipe3_data",  out_data,  pipe_exp[3]);
        tick();
        check("pipe_idle_valid", out_valid, 0);

        // ---- Config beats ignored in RUN ----
        cfg_valid = 1'b1;
        cfg_data  = 8'hFF;
        cfg_last  = 1'b1;
        cfg_par   = 1'b0;
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        check("run_ignore_loaded", loaded,  1);
        check("run_ignore_err",    cfg_err, 0);
        lookup(addr_zero);
        check("run_ignore_data", out_data, 8'h00);

        // ---- cfg_last on beat 10 ----
        pulse_reload();
        send_cfg(tbl_a5, 11, 10, -1);
        check("early_last_err",   cfg_err,   1);
        check("early_last_ld",    loaded,    0);
        check("early_last_ready", cfg_ready, 1);
        lookup(addr_zero);
        check("early_last_drop", out_valid, 0);
        send_cfg(tbl_a5, 64, 63, -1);
        check("recover_err", cfg_err, 0);
        check("recover_ld",  loaded,  1);
        lookup(addr_idx);
        check("recover_data", out_data, 8'hA5);

        // ---- cfg_last missing on beat 63 ----
        pulse_reload();
        send_cfg(tbl_oh, 64, -1, -1);
        check("no_last_err", cfg_err, 1);
        check("no_last_ld",  loaded,  0);

        // ---- rst at beat 30 ----
        send_cfg(tbl_oh, 30, -1, -1);
        check("midload_ld",  loaded,  0);
        check("midload_err", cfg_err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_err",   cfg_err,   0);
        check("midrst_ld",    loaded,    0);
        check("midrst_ready", cfg_ready, 1);
        send_cfg(tbl_oh, 64, 63, -1);
        check("after_rst_ld",  loaded,  1);
        check("after_rst_err", cfg_err, 0);
        lookup(addr_n3);
        check("after_rst_data", out_data, 8'h08);

        // ---- Bad parity on beat 5 ----
        pulse_reload();
        send_cfg(tbl_a5, 64, 63, 5);
`ifdef LUT_LOADER_PARITY_EN
        exp_err = 1'b1;
        exp_ld  = 1'b0;
`else
        exp_err = 1'b0;
        exp_ld  = 1'b1;
`endif
        check("parity_err", cfg_err, exp_err);
        check("parity_ld",  loaded,  exp_ld);
        lookup(addr_idx);
        check("parity_valid", out_valid, exp_ld);
`ifndef LUT_LOADER_PARITY_EN
        check("parity_data", out_data, 8'hA5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
